// File: rtl/sram_uart_tx_interface_pkg.sv
// Shared constants and state types for the SRAM-to-UART transmit path.
package sram_uart_tx_interface_pkg;

  localparam int UART_CLKS_PER_BIT_115200 = 434;
  localparam int SRAM_ADDR_W              = 18;
  localparam int SRAM_DATA_W              = 16;

  typedef enum logic [2:0] {
    S_TXI_IDLE,
    S_TXI_READ,
    S_TXI_WAIT,
    S_TXI_CAPTURE,
    S_TXI_SEND_HI,
    S_TXI_SEND_LO,
    S_TXI_DONE
`ifdef SRAM_UART_TX_CHECKSUM_EN
    , S_TXI_CHECKSUM
`endif
  } SRAM_UART_TX_state_type;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } uart_tx_state_type;

endpackage

// File: rtl/sram_uart_tx_interface_uart_tx_byte.sv
// 8N1 byte serialiser with a valid/ready handshake; ready also rises in the last
// stop-bit cycle so consecutive bytes go out back-to-back.
module sram_uart_tx_interface_uart_tx_byte
  import sram_uart_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Tx_data,
  input  logic       Tx_valid,
  output logic       Tx_ready,
  output logic       UART_TX_O
);

  localparam int                 TIMER_W  = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] BIT_LAST = TIMER_W'(CLKS_PER_BIT - 1);

  uart_tx_state_type  state;
  logic [TIMER_W-1:0] bit_timer;
  logic [2:0]         bit_index;
  logic [7:0]         shift_q;
  logic               bit_end;

  assign bit_end  = (bit_timer == BIT_LAST);
  assign Tx_ready = (state == TX_IDLE) || ((state == TX_STOP) && bit_end);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= TX_IDLE;
      bit_timer <= '0;
      bit_index <= '0;
      shift_q   <= '0;
      UART_TX_O <= 1'b1;
    end else begin
      bit_timer <= ((state == TX_IDLE) || bit_end) ? '0 : bit_timer + 1'b1;
      unique case (state)
        TX_IDLE: begin
          if (Tx_valid) begin
            state     <= TX_START;
            shift_q   <= Tx_data;
            UART_TX_O <= 1'b0;
          end
        end
        TX_START: begin
          if (bit_end) begin
            state     <= TX_DATA;
            bit_index <= '0;
            UART_TX_O <= shift_q[0];
            shift_q   <= shift_q >> 1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            if (bit_index == 3'd7) begin
              state     <= TX_STOP;
              UART_TX_O <= 1'b1;
            end else begin
              bit_index <= bit_index + 1'b1;
              UART_TX_O <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            if (Tx_valid) begin
              state     <= TX_START;
              shift_q   <= Tx_data;
              UART_TX_O <= 1'b0;
            end else begin
              state <= TX_IDLE;
            end
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sram_uart_tx_interface.sv
// Reads Word_count SRAM words from Start_address and sends each as two UART frames,
// high byte first. Define SRAM_UART_TX_CHECKSUM_EN to append an XOR trailer frame.
module sram_uart_tx_interface
  import sram_uart_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
  parameter int READ_LATENCY = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [SRAM_ADDR_W-1:0] Start_address,
  input  logic [SRAM_ADDR_W-1:0] Word_count,
  output logic [SRAM_ADDR_W-1:0] SRAM_address,
  input  logic [SRAM_DATA_W-1:0] SRAM_read_data,
  output logic                   SRAM_we_n,
  output logic                   UART_TX_O,
  output logic                   Busy,
  output logic                   Done
);

  localparam int                WAIT_W    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 2);

  SRAM_UART_TX_state_type state;
  logic [SRAM_ADDR_W-1:0] words_left;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [SRAM_DATA_W-1:0] word_q;
  logic                   byte_sent;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
`ifdef SRAM_UART_TX_CHECKSUM_EN
  logic [7:0]             checksum;
`endif

  assign SRAM_we_n = 1'b1;

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = word_q[15:8];
    unique case (state)
      S_TXI_SEND_HI: tx_valid = 1'b1;
      S_TXI_SEND_LO: begin
        tx_valid = !byte_sent;
        tx_data  = word_q[7:0];
      end
`ifdef SRAM_UART_TX_CHECKSUM_EN
      S_TXI_CHECKSUM: begin
        tx_valid = !byte_sent;
        tx_data  = checksum;
      end
`endif
      default: ;
    endcase
  end

  // byte_sent splits SEND_LO (and CHECKSUM) into hand-off and wait-for-last-stop-cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= S_TXI_IDLE;
      SRAM_address <= '0;
      words_left   <= '0;
      wait_cnt     <= '0;
      word_q       <= '0;
      byte_sent    <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        S_TXI_IDLE: begin
          if (Start) begin
            SRAM_address <= Start_address;
            words_left   <= Word_count;
            if (Word_count == '0) begin
              state <= S_TXI_DONE;
              Done  <= 1'b1;
            end else begin
              state <= S_TXI_READ;
              Busy  <= 1'b1;
            end
          end
        end
        S_TXI_READ: begin
          wait_cnt <= '0;
          state    <= (READ_LATENCY > 1) ? S_TXI_WAIT : S_TXI_CAPTURE;
        end
        S_TXI_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= S_TXI_CAPTURE;
          else                       wait_cnt <= wait_cnt + 1'b1;
        end
        S_TXI_CAPTURE: begin
          word_q <= SRAM_read_data;
          state  <= S_TXI_SEND_HI;
        end
        S_TXI_SEND_HI: begin
          if (tx_ready) begin
            state     <= S_TXI_SEND_LO;
            byte_sent <= 1'b0;
          end
        end
        S_TXI_SEND_LO: begin
          if (tx_ready) begin
            if (!byte_sent) begin
              byte_sent <= 1'b1;
            end else if (words_left != SRAM_ADDR_W'(1)) begin
              words_left   <= words_left - 1'b1;
              SRAM_address <= SRAM_address + 1'b1;
              state        <= S_TXI_READ;
            end else begin
`ifdef SRAM_UART_TX_CHECKSUM_EN
              state     <= S_TXI_CHECKSUM;
              byte_sent <= 1'b0;
`else
              state <= S_TXI_DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
`endif
            end
          end
        end
`ifdef SRAM_UART_TX_CHECKSUM_EN
        S_TXI_CHECKSUM: begin
          if (tx_ready) begin
            if (!byte_sent) begin
              byte_sent <= 1'b1;
            end else begin
              state <= S_TXI_DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end
          end
        end
`endif
        S_TXI_DONE: state <= S_TXI_IDLE;
        default:    state <= S_TXI_IDLE;
      endcase
    end
  end

`ifdef SRAM_UART_TX_CHECKSUM_EN
  always_ff @(posedge Clock) begin
    if (Reset || (state == S_TXI_IDLE)) begin
      checksum <= '0;
    end else if (tx_valid && tx_ready && (state != S_TXI_CHECKSUM)) begin
      checksum <= checksum ^ tx_data;
    end
  end
`endif

  sram_uart_tx_interface_uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .Clock     (Clock),
    .Reset     (Reset),
    .Tx_data   (tx_data),
    .Tx_valid  (tx_valid),
    .Tx_ready  (tx_ready),
    .UART_TX_O (UART_TX_O)
  );

endmodule

// File: tb/tb_sram_uart_tx_interface.sv
// Bench for sram_uart_tx_interface: table vectors, randomized transfers and a
// mid-frame reset, checked against a timing/frame model built from the protocol rules.
module tb_sram_uart_tx_interface;

  localparam int C     = 4;
  localparam int L     = 2;
  localparam int FRAME = 10 * C;
  localparam int P     = L + 2 + 2 * FRAME;
`ifdef SRAM_UART_TX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int CKX  = CK ? FRAME + 1 : 0;
  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [17:0] Start_address = '0;
  logic [17:0] Word_count = '0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        SRAM_we_n;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  logic [15:0] mem [0:(1 << 18) - 1];
  logic [15:0] rd_pipe;
  bit          line_s [MAXC];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [17:0] addr;
    logic [17:0] cnt;
    logic [15:0] w [3];
    int          glitch;
    int          exp_done;
  } vec_t;

  vec_t vt [5];

  always #5 clk = ~clk;

  // SRAM model: data appears L=2 cycles after the address changes.
  always @(posedge clk) begin
    rd_pipe        <= mem[SRAM_address];
    SRAM_read_data <= rd_pipe;
  end

  sram_uart_tx_interface #(
    .CLKS_PER_BIT (C),
    .READ_LATENCY (L)
  ) dut (
    .Clock          (clk),
    .Reset          (Reset),
    .Start          (Start),
    .Start_address  (Start_address),
    .Word_count     (Word_count),
    .SRAM_address   (SRAM_address),
    .SRAM_read_data (SRAM_read_data),
    .SRAM_we_n      (SRAM_we_n),
    .UART_TX_O      (UART_TX_O),
    .Busy           (Busy),
    .Done           (Done)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Cycle 0 is the cycle right after the edge that samples Start.
  task automatic run_xfer(input string tag, input logic [17:0] a, input logic [17:0] cnt,
                          input int glitch_at, input int exp_done);
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    logic [17:0] cap_addr [$];
    logic [7:0]  ck_x;
    bit          exp_line [MAXC];
    int          span, done_at, done_pulses, busy_cycles, wave_err, i, n_cmp;
    ck_x = 8'h00;
    for (int w = 0; w < int'(cnt); w++) begin
      logic [15:0] d;
      d = mem[18'(a + 18'(w))];
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
      ck_x = ck_x ^ d[15:8] ^ d[7:0];
    end
    if (CK && cnt != 0) exp_q.push_back(ck_x);
    span = exp_done + 6;
    for (int n = 0; n < MAXC; n++) exp_line[n] = 1'b1;
    foreach (exp_q[k]) begin
      int s;
      if (k < 2 * int'(cnt)) s = (k / 2) * P + L + 2 + (k % 2) * FRAME;
      else                   s = int'(cnt) * P + 1;
      for (int b = 0; b < 10; b++)
        for (int c = 0; c < C; c++)
          exp_line[s + b * C + c] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_q[k][b - 1];
    end

    @(negedge clk);
    Start_address = a;
    Word_count    = cnt;
    Start         = 1'b1;
    done_at = -1; done_pulses = 0; busy_cycles = 0; wave_err = 0;
    for (int n = 0; n < span; n++) begin
      @(negedge clk);
      line_s[n] = UART_TX_O;
      if (UART_TX_O !== exp_line[n]) wave_err++;
      if (Done) begin
        done_pulses++;
        if (done_at < 0) done_at = n;
      end
      if (Busy) busy_cycles++;
      if ((n % P == L) && (n / P < int'(cnt))) cap_addr.push_back(SRAM_address);
      Start = (n == glitch_at);
      if (n == glitch_at) begin
        Start_address = a ^ 18'h00155;
        Word_count    = 18'd5;
      end
    end
    Start = 1'b0;

    i = 0;
    while (i < span) begin
      if (line_s[i] == 1'b0 && i + FRAME <= span) begin
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = line_s[i + C * (b + 1) + C / 2];
        got_q.push_back(v);
        i += FRAME;
      end else begin
        i++;
      end
    end

    check({tag, "_done_cycle"}, done_at, exp_done);
    check({tag, "_done_pulses"}, done_pulses, 1);
    check({tag, "_busy_cycles"}, busy_cycles, exp_done);
    check({tag, "_line_wave_errs"}, wave_err, 0);
    check({tag, "_frame_count"}, got_q.size(), exp_q.size());
    n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n_cmp; k++)
      check($sformatf("%s_frame%0d", tag, k), got_q[k], exp_q[k]);
    foreach (cap_addr[w])
      check($sformatf("%s_addr%0d", tag, w), cap_addr[w], 18'(a + 18'(w)));
  endtask

  initial begin
    int lows, busy_hi;

    vt[0] = '{18'h00010, 18'd1, '{16'hA55A, 16'h0000, 16'h0000}, -1, P + CKX};
    vt[1] = '{18'h3FFFE, 18'd3, '{16'h1234, 16'h5678, 16'h9ABC}, -1, 3 * P + CKX};
    vt[2] = '{18'h00100, 18'd0, '{16'hFFFF, 16'hFFFF, 16'hFFFF}, -1, 0};
    vt[3] = '{18'h00200, 18'd2, '{16'hBEEF, 16'h0F0F, 16'h0000}, 50, 2 * P + CKX};
    vt[4] = '{18'h00300, 18'd2, '{16'h0102, 16'h0304, 16'h0000}, -1, 2 * P + CKX};

    repeat (3) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    check("reset_sram_address", SRAM_address, 18'h0);
    check("reset_uart_line", UART_TX_O, 1'b1);
    check("reset_busy", Busy, 1'b0);
    check("reset_done", Done, 1'b0);
    check("sram_we_n", SRAM_we_n, 1'b1);

    foreach (vt[v]) begin
      for (int k = 0; k < 3; k++) mem[18'(vt[v].addr + 18'(k))] = vt[v].w[k];
      run_xfer($sformatf("vec%0d", v), vt[v].addr, vt[v].cnt, vt[v].glitch, vt[v].exp_done);
    end

    for (int r = 0; r < 6; r++) begin
      logic [17:0] a, c;
      int g, ed;
      a = (r % 2 == 1) ? 18'h3FFFF - 18'($urandom_range(0, 2)) : 18'($urandom);
      c = (r == 5) ? 18'd0 : 18'($urandom_range(1, 4));
      for (int k = 0; k < int'(c); k++) mem[18'(a + 18'(k))] = 16'($urandom);
      ed = (c == 0) ? 0 : int'(c) * P + CKX;
      g  = (ed >= 3 && r % 3 != 0) ? int'($urandom_range(1, ed - 2)) : -1;
      run_xfer($sformatf("rnd%0d", r), a, c, g, ed);
    end

    // Reset during the second data bit of the high byte (0xA5 -> bit1 = 0).
    mem[18'h00020] = 16'hA55A;
    @(negedge clk);
    Start_address = 18'h00020;
    Word_count    = 18'd1;
    Start         = 1'b1;
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      Start = 1'b0;
    end
    check("rst_mid_frame_line_before", UART_TX_O, 1'b0);
    Reset = 1'b1;
    @(negedge clk);
    check("rst_mid_frame_line", UART_TX_O, 1'b1);
    check("rst_mid_frame_busy", Busy, 1'b0);
    check("rst_mid_frame_done", Done, 1'b0);
    Reset = 1'b0;
    lows = 0;
    busy_hi = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!UART_TX_O) lows++;
      if (Busy) busy_hi++;
    end
    check("rst_no_resume_line_lows", lows, 0);
    check("rst_no_resume_busy", busy_hi, 0);
    run_xfer("after_rst", 18'h00020, 18'd1, -1, P + CKX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
